// File: rtl/threshold_scan_ctrl.sv
// Time-multiplexes one external 8-bit threshold comparator across NCH channels.
// Each channel's result is debounced into a trip flag, and the trip flags are ORed into out_o.
module threshold_scan_ctrl #(
    parameter int NCH      = 4,
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic                    cfg_we_i,
    input  logic [$clog2(NCH)-1:0]  cfg_addr_i,
    input  logic [7:0]              cfg_data_i,
    input  logic                    t_g_gt_i,
    output logic [7:0]              gt_o,
    output logic [$clog2(NCH)-1:0]  ch_sel_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NCH-1:0]          trip_o,
    output logic                    out_o
);

    localparam int CW = $clog2(NCH);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_SAMPLE = 2'd3;

    logic [1:0]     state_q,  state_d;
    logic [CW-1:0]  ch_q,     ch_d;
    logic [SW-1:0]  wait_q,   wait_d;
    logic [7:0]     gt_q,     gt_d;
    logic [CW-1:0]  ch_sel_q, ch_sel_d;
    logic           done_q,   done_d;
    logic [NCH-1:0] trip_q,   trip_d;
    logic           out_q,    out_d;
    logic [DW-1:0]  cnt_q [NCH];
    logic [DW-1:0]  cnt_d [NCH];
    logic [7:0]     thr_q [NCH];
    logic [7:0]     thr_d [NCH];
    logic [DW-1:0]  cnt_inc;

    assign cnt_inc = cnt_q[ch_q] + DW'(1);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wait_d   = wait_q;
        gt_d     = gt_q;
        ch_sel_d = ch_sel_q;
        done_d   = 1'b0;
        trip_d   = trip_q;
        cnt_d    = cnt_q;
        thr_d    = thr_q;
        out_d    = |trip_q;

        // LOAD reads thr_q, so a write landing on the same edge only affects later slots.
        if (cfg_we_i) begin
            thr_d[cfg_addr_i] = cfg_data_i;
        end

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end
            end
            S_LOAD: begin
                gt_d     = thr_q[ch_q];
                ch_sel_d = ch_q;
                wait_d   = SW'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q - SW'(1);
                end
            end
            S_SAMPLE: begin
                if (t_g_gt_i == trip_q[ch_q]) begin
                    cnt_d[ch_q] = '0;
                end else if (cnt_inc == DW'(DEBOUNCE)) begin
                    trip_d[ch_q] = ~trip_q[ch_q];
                    cnt_d[ch_q]  = '0;
                end else begin
                    cnt_d[ch_q] = cnt_inc;
                end

                if (ch_q == CW'(NCH - 1)) begin
                    done_d  = 1'b1;
                    ch_d    = '0;
                    state_d = run_i ? S_LOAD : S_IDLE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            wait_q   <= '0;
            gt_q     <= '0;
            ch_sel_q <= '0;
            done_q   <= 1'b0;
            trip_q   <= '0;
            out_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                thr_q[i] <= 8'hFF;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            wait_q   <= wait_d;
            gt_q     <= gt_d;
            ch_sel_q <= ch_sel_d;
            done_q   <= done_d;
            trip_q   <= trip_d;
            out_q    <= out_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                thr_q[i] <= thr_d[i];
            end
        end
    end

    assign gt_o     = gt_q;
    assign ch_sel_o = ch_sel_q;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign trip_o   = trip_q;
    assign out_o    = out_q;

endmodule

// File: tb/tb_threshold_scan_ctrl.sv
// Bench for threshold_scan_ctrl: a slot scoreboard for gt/ch_sel, a per-scan debounce
// vector table, and hand-written sequences for reset, config-write and run-drop corners.
module tb_threshold_scan_ctrl;

    localparam int NCH      = 4;
    localparam int SETTLE   = 2;
    localparam int DEBOUNCE = 3;
    localparam int SLOT     = SETTLE + 2;
    localparam int CW       = $clog2(NCH);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic           cfgWe = 1'b0;
    logic [CW-1:0]  cfgAddr = '0;
    logic [7:0]     cfgData = '0;
    logic [NCH-1:0] respMask = '0;
    logic           tGGt;
    logic [7:0]     gt;
    logic [CW-1:0]  chSel;
    logic           busy;
    logic           done;
    logic [NCH-1:0] trip;
    logic           out;

    threshold_scan_ctrl #(.NCH(NCH), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .run_i      (run),
        .cfg_we_i   (cfgWe),
        .cfg_addr_i (cfgAddr),
        .cfg_data_i (cfgData),
        .t_g_gt_i   (tGGt),
        .gt_o       (gt),
        .ch_sel_o   (chSel),
        .busy_o     (busy),
        .done_o     (done),
        .trip_o     (trip),
        .out_o      (out)
    );

    always #5 clk = ~clk;

    // The comparator model answers from a per-channel mask indexed by the channel in flight.
    assign tGGt = respMask[chSel];

    typedef struct {
        logic [CW-1:0] ch;
        logic [7:0]    gt;
    } slot_t;

    typedef struct {
        logic [NCH-1:0] mask;
        logic [NCH-1:0] expTrip;
        logic           expOut;
    } vec_t;

    slot_t      expQ[$];
    slot_t      curExp;
    bit         haveExp = 1'b0;
    bit         sbEn = 1'b0;
    bit         prevBusy = 1'b0;
    int         slotPos = 0;
    logic [7:0] thrModel [NCH];
    vec_t       vecs [15];
    int         total = 0;
    int         bad = 0;
    int         n;
    int         doneCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushScan();
        slot_t s;
        for (int i = 0; i < NCH; i++) begin
            s.ch = CW'(i);
            s.gt = thrModel[i];
            expQ.push_back(s);
        end
    endtask

    task automatic waitDone();
        int k = 0;
        do begin
            tick();
            k++;
        end while (done !== 1'b1 && k < 100);
        if (done !== 1'b1) checkOutput("done timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic writeThr(input logic [CW-1:0] a, input logic [7:0] d);
        cfgWe   = 1'b1;
        cfgAddr = a;
        cfgData = d;
        tick();
        cfgWe = 1'b0;
        thrModel[a] = d;
    endtask

    task automatic doReset();
        rst = 1'b1;
        run = 1'b0;
        cfgWe = 1'b0;
        respMask = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NCH; i++) thrModel[i] = 8'hFF;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        respMask = v.mask;
        waitDone();
        checkOutput($sformatf("row%0d trip", idx), 32'(trip), 32'(v.expTrip));
        tick();
        checkOutput($sformatf("row%0d out", idx), {31'd0, out}, {31'd0, v.expOut});
    endtask

    // Slot monitor: gt/ch_sel must show the queued expectation from the cycle after LOAD to slot end.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (!prevBusy) slotPos = 0;
            else slotPos = (slotPos == SLOT - 1) ? 0 : slotPos + 1;
            if (sbEn && slotPos == 1) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb pending", 32'(expQ.size()), 32'd1);
                end else begin
                    curExp  = expQ.pop_front();
                    haveExp = 1'b1;
                end
            end
            if (sbEn && haveExp && slotPos >= 1) begin
                checkOutput("slot ch_sel", 32'(chSel), 32'(curExp.ch));
                checkOutput("slot gt", 32'(gt), 32'(curExp.gt));
            end
        end
        prevBusy = (busy === 1'b1);
    end

    initial begin
        vecs[0]  = '{4'b0100, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0100, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0100, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0100, 1'b1};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0000, 1'b0};
        vecs[7]  = '{4'b0010, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 1'b0};
        vecs[10] = '{4'b0010, 4'b0000, 1'b0};
        vecs[11] = '{4'b0010, 4'b0010, 1'b1};
        vecs[12] = '{4'b0000, 4'b0010, 1'b1};
        vecs[13] = '{4'b0000, 4'b0010, 1'b1};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0};

        doReset();
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset gt", 32'(gt), 32'd0);
        checkOutput("reset ch_sel", 32'(chSel), 32'd0);
        checkOutput("reset trip", 32'(trip), 32'd0);
        checkOutput("reset out", {31'd0, out}, 32'd0);

        // Single scan with a one-cycle run pulse.
        writeThr(2'd0, 8'd10);
        writeThr(2'd1, 8'd20);
        writeThr(2'd2, 8'd30);
        writeThr(2'd3, 8'd40);
        sbEn = 1'b1;
        pushScan();
        run = 1'b1;
        tick();
        checkOutput("scan busy in LOAD", {31'd0, busy}, 32'd1);
        run = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("scan done latency", 32'(n), 32'(NCH * SLOT));
        checkOutput("busy at done", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("done one cycle", {31'd0, done}, 32'd0);
        checkOutput("gt holds in idle", 32'(gt), 32'd40);
        checkOutput("sb drained scan", 32'(expQ.size()), 32'd0);

        // Write thr[3] during its own SETTLE, then drop run during ch1 SETTLE of the next scan.
        pushScan();
        thrModel[3] = 8'h55;
        pushScan();
        thrModel[3] = 8'd40;
        run = 1'b1;
        tick();
        for (int i = 0; i < 3 * SLOT + 1; i++) tick();
        writeThr(2'd3, 8'h55);
        for (int i = 0; i < 7; i++) tick();
        run = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) doneCnt++;
        end
        checkOutput("run drop done count", 32'(doneCnt), 32'd1);
        checkOutput("run drop idle", {31'd0, busy}, 32'd0);
        checkOutput("run drop gt", 32'(gt), 32'h55);
        checkOutput("run drop ch_sel", 32'(chSel), 32'd3);
        checkOutput("sb drained write", 32'(expQ.size()), 32'd0);
        sbEn = 1'b0;

        // Debounce set/clear and glitch rejection, one table row per scan.
        doReset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        // out lags trip by one cycle: ch3 trips on the same edge that raises done.
        respMask = 4'b1000;
        waitDone();
        checkOutput("ch3 scan1 trip", 32'(trip), 32'd0);
        waitDone();
        checkOutput("ch3 scan2 trip", 32'(trip), 32'd0);
        waitDone();
        checkOutput("ch3 scan3 trip", 32'(trip), 32'b1000);
        checkOutput("ch3 out lag", {31'd0, out}, 32'd0);
        tick();
        checkOutput("ch3 out set", {31'd0, out}, 32'd1);

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst busy", {31'd0, busy}, 32'd0);
        checkOutput("async rst gt", 32'(gt), 32'd0);
        checkOutput("async rst trip", 32'(trip), 32'd0);
        checkOutput("async rst out", {31'd0, out}, 32'd0);
        run = 1'b0;
        respMask = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) thrModel[i] = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("idle after rst busy", {31'd0, busy}, 32'd0);
        checkOutput("idle after rst gt", 32'(gt), 32'd0);
        sbEn = 1'b1;
        pushScan();
        run = 1'b1;
        tick();
        run = 1'b0;
        waitDone();
        tick();
        checkOutput("sb drained reset", 32'(expQ.size()), 32'd0);
        sbEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threshold_scan_ctrl.md
Name: threshold_scan_ctrl

Overview:
Sequencer for the shared 8-bit threshold comparator (gt threshold in, t_g_gt result out) in the control path. It holds NCH programmable thresholds and time-multiplexes the single comparator across NCH channels. For each channel it drives gt, waits for the comparator to settle, and samples t_g_gt. It debounces each channel's result into a trip flag and ORs the trip flags into out.

Parameters:
NCH, 4, number of channels/thresholds scanned (power of 2, 2..8)
SETTLE, 2, cycles between driving gt and sampling t_g_gt (>=1)
DEBOUNCE, 3, consecutive identical samples required to set or clear a trip flag (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
run  input  1  level; scanning continues while high
cfg_we  input  1  threshold write strobe
cfg_addr  input  log2(NCH)  threshold index to write
cfg_data  input  8  threshold value
t_g_gt  input  1  comparator result for currently driven gt
gt  output  8  threshold presented to comparator (registered)
ch_sel  output  log2(NCH)  channel currently being compared (registered)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at completion of each full scan
trip  output  NCH  debounced per-channel result
out  output  1  OR of trip, registered

Behaviour:
- Reset (async, any time including mid-scan) clears:
  - state->IDLE; gt=0, ch_sel=0, busy=0, done=0, trip=0, out=0.
  - All debounce counters = 0.
  - All thresholds = 8'hFF.
- FSM states:
  - IDLE: if run=1, go to LOAD with ch=0; otherwise stay.
  - LOAD (1 cycle): gt<=thr[ch], ch_sel<=ch; go to SETTLE with wait counter=SETTLE-1.
  - SETTLE (SETTLE cycles): decrement the counter; at 0, go to SAMPLE.
  - SAMPLE (1 cycle): capture t_g_gt and update channel ch's debounce state.
    - ch<NCH-1: ch<=ch+1, go to LOAD.
    - ch=NCH-1: pulse done the next cycle; go to LOAD with ch=0 if run=1, else IDLE.
- Timing:
  - Per-channel slot = SETTLE+2 cycles; full scan = NCH*(SETTLE+2) cycles (16 at defaults).
  - done rises the cycle after the last SAMPLE.
- run deassertion mid-scan: the current scan completes, done pulses, then IDLE. No partial scans.
- gt and ch_sel hold their last values in IDLE.
- Debounce, per channel:
  - Counter width log2(DEBOUNCE+1).
  - A sample that differs from trip[ch] increments the counter.
  - A sample equal to trip[ch] clears the counter to 0.
  - When the counter reaches DEBOUNCE, trip[ch] toggles and the counter clears. Updates happen in SAMPLE only.
  - With DEBOUNCE=1, trip follows each sample directly.
- out is registered: out = |trip, one cycle after the trip update.
- Config writes:
  - Accepted in any state; thr[cfg_addr]<=cfg_data on the cycle cfg_we=1.
  - gt is latched only in LOAD, so a write to the channel in flight takes effect on that channel's next slot.
  - Simultaneous write and LOAD of the same index: LOAD uses the old value.
- Threshold compare semantics belong to the external comparator; this block only drives gt and samples t_g_gt.

Test Plan:
1. Reset values: assert rst mid-scan at cycle 7 -> same edge: busy=0, gt=0, trip=0, out=0. After release with run=0 -> block stays IDLE; thr reads back as FF on the next scan (gt=FF for ch0).
2. Single scan: write thr={10,20,30,40}, pulse run for 1 cycle.
   - gt steps 10,20,30,40 with ch_sel 0..3, each held 4 cycles.
   - done pulses exactly 16 cycles after LOAD ch0 starts; busy then drops.
3. Debounce set/clear: run continuous, t_g_gt=1 only while ch_sel=2.
   - trip[2] sets after the 3rd scan's SAMPLE; out rises 1 cycle later.
   - Then force t_g_gt=0: trip[2] clears after 3 scans; other trip bits stay 0.
4. Glitch rejection: t_g_gt=1 for ch1 on scans 1-2, 0 on scan 3, 1 on scans 4-5 -> trip[1] stays 0 (counter reset by scan 3).
5. Write during slot: in SETTLE of ch3, write thr[3]=0x55 -> gt stays at the old value for this slot and shows 0x55 on the next scan's ch3 slot.
6. run drop mid-scan: drop run during ch1 SETTLE -> ch2 and ch3 are still scanned, done pulses once, then IDLE with gt holding thr[3].
